// File: rtl/fifo_sm.sv
// Multi-source, single-sink tagged FIFO: FLUX write streams, each with its own
// DEPTH-entry queue, merged onto one first-word-fall-through read port by a round-robin arbiter.
module fifo_sm #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int FLUX       = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [FLUX*DATA_WIDTH-1:0]         din,
   input  logic [FLUX-1:0]                    write,
   output logic [FLUX-1:0]                    full,
   output logic [DATA_WIDTH+$clog2(FLUX)-1:0] dout,
   input  logic                               read,
   output logic                               empty
);

   localparam int TAG_W = $clog2(FLUX);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // Handshake: write[i] transfers din slice i when !full[i]; a word leaves when
   // read && !empty. dout is valid whenever empty is low and is zero otherwise.

   logic [DATA_WIDTH-1:0] mem_q    [FLUX][DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q [FLUX];
   logic [PTR_W-1:0]      wr_ptr_d [FLUX];
   logic [PTR_W-1:0]      rd_ptr_q [FLUX];
   logic [PTR_W-1:0]      rd_ptr_d [FLUX];
   logic [CNT_W-1:0]      cnt_q    [FLUX];
   logic [CNT_W-1:0]      cnt_d    [FLUX];
   logic [TAG_W-1:0]      rr_ptr_q;
   logic [TAG_W-1:0]      rr_ptr_d;
   logic [TAG_W-1:0]      sel;
   logic [FLUX-1:0]       nonempty;
   logic [FLUX-1:0]       push;
   logic [FLUX-1:0]       pop;

   function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= FLUX) s = s - FLUX;
      return TAG_W'(s);
   endfunction

   always_comb begin
      nonempty = '0;
      full     = '0;
      for (int i = 0; i < FLUX; i++) begin
         nonempty[i] = (cnt_q[i] != '0);
         full[i]     = (cnt_q[i] == CNT_W'(DEPTH));
      end
   end

   // Scan downwards so the stream closest to rr_ptr wins by being assigned last.
   always_comb begin
      sel = rr_ptr_q;
      for (int k = FLUX - 1; k >= 0; k--) begin
         if (nonempty[wrap_add(rr_ptr_q, k)]) sel = wrap_add(rr_ptr_q, k);
      end
   end

   assign empty = ~|nonempty;
   assign dout  = empty ? '0 : {sel, mem_q[sel][rd_ptr_q[sel]]};

   always_comb begin
      push     = write & ~full;
      pop      = '0;
      rr_ptr_d = rr_ptr_q;
      for (int i = 0; i < FLUX; i++) begin
         pop[i]      = read && !empty && (sel == TAG_W'(i));
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
         cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (read && !empty) rr_ptr_d = wrap_add(sel, 1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= '0;
         for (int i = 0; i < FLUX; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < FLUX; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset: counts gate every read of it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FLUX; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_fifo_sm.sv
// Bench for fifo_sm (DATA_WIDTH=8, DEPTH=4, FLUX=2): scoreboard of expected {tag,payload}
// words, pushed when stimulus is driven and popped when the read port delivers.
module tb_fifo_sm;

   logic        clk;
   logic        rst;
   logic [15:0] din;
   logic [1:0]  write;
   logic [1:0]  full;
   logic [9:0]  dout;
   logic        read;
   logic        empty;

   logic [9:0]  exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   fifo_sm #(.DATA_WIDTH(8), .DEPTH(4), .FLUX(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .write (write),
      .full  (full),
      .dout  (dout),
      .read  (read),
      .empty (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic drive_push(input logic [1:0] w, input logic [7:0] d0, input logic [7:0] d1);
      write = w;
      din   = {d1, d0};
      @(posedge clk); #1;
      write = '0;
   endtask

   task automatic pop_check(input string name);
      logic [9:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: scoreboard empty, dout=%h empty=%b", name, dout, empty);
      end else begin
         e = exp_q.pop_front();
         if (empty !== 1'b0 || dout !== e) begin
            n_errors++;
            $display("FAIL %s: empty=%b dout=%h, required empty=0 dout=%h", name, empty, dout, e);
         end
      end
      read = 1'b1;
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic check_flags(input string name, input logic [1:0] exp_full, input logic exp_empty);
      n_checks++;
      if (full !== exp_full || empty !== exp_empty) begin
         n_errors++;
         $display("FAIL %s: full=%b empty=%b, required full=%b empty=%b",
                  name, full, empty, exp_full, exp_empty);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      check_flags("reset_held", 2'b00, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_flags("reset_release", 2'b00, 1'b1);
      n_checks++;
      if (dout !== 10'h000) begin
         n_errors++;
         $display("FAIL reset_dout: dout=%h, required 000", dout);
      end
      write = 2'b10;
      din   = {8'hA5, 8'h00};
      #2;
      check_flags("push_not_yet_visible", 2'b00, 1'b1);
      @(posedge clk); #1;
      write = '0;
      exp_q.push_back({1'b1, 8'hA5});
      pop_check("reset_first_word");
      check_flags("reset_after_pop", 2'b00, 1'b1);
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 4; i++) begin
         drive_push(2'b01, 8'(i), 8'h00);
         exp_q.push_back({1'b0, 8'(i)});
      end
      check_flags("fill_full", 2'b01, 1'b0);
      drive_push(2'b01, 8'h05, 8'h00);
      check_flags("fill_drop_still_full", 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) pop_check("fill_drain");
      check_flags("fill_drained", 2'b00, 1'b1);
   endtask

   task automatic test_round_robin();
      do_reset();
      drive_push(2'b11, 8'h10, 8'h20);
      drive_push(2'b11, 8'h11, 8'h21);
      exp_q.push_back({1'b0, 8'h10});
      exp_q.push_back({1'b1, 8'h20});
      exp_q.push_back({1'b0, 8'h11});
      exp_q.push_back({1'b1, 8'h21});
      for (int i = 0; i < 4; i++) pop_check("rr_order");
      check_flags("rr_drained", 2'b00, 1'b1);
   endtask

   task automatic test_full_push_pop();
      logic [9:0] e;
      for (int i = 0; i < 4; i++) begin
         drive_push(2'b10, 8'h00, 8'(8'h30 + i));
         exp_q.push_back({1'b1, 8'(8'h30 + i)});
      end
      check_flags("s1_full", 2'b10, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (dout !== e) begin
         n_errors++;
         $display("FAIL full_pushpop_head: dout=%h, required %h", dout, e);
      end
      write = 2'b10;
      din   = {8'h55, 8'h00};
      read  = 1'b1;
      @(posedge clk); #1;
      write = '0;
      read  = 1'b0;
      check_flags("full_deassert", 2'b00, 1'b0);
      drive_push(2'b10, 8'h00, 8'h55);
      exp_q.push_back({1'b1, 8'h55});
      check_flags("retry_full", 2'b10, 1'b0);
      for (int i = 0; i < 4; i++) pop_check("full_pushpop_drain");
      check_flags("full_pushpop_drained", 2'b00, 1'b1);
   endtask

   task automatic test_wrap();
      drive_push(2'b01, 8'h00, 8'h00);
      exp_q.push_back({1'b0, 8'h00});
      for (int i = 1; i < 10; i++) begin
         exp_q.push_back({1'b0, 8'(i)});
         write = 2'b01;
         din   = {8'h00, 8'(i)};
         pop_check("wrap_pushpop");
         write = '0;
         check_flags("wrap_count_one", 2'b00, 1'b0);
      end
      pop_check("wrap_last");
      check_flags("wrap_drained", 2'b00, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive_push(2'b11, 8'(8'h40 + i), 8'(8'h50 + i));
      check_flags("mid_loaded", 2'b00, 1'b0);
      rst = 1'b0;
      #1;
      check_flags("mid_async_clear", 2'b00, 1'b1);
      n_checks++;
      if (dout !== 10'h000) begin
         n_errors++;
         $display("FAIL mid_async_dout: dout=%h, required 000", dout);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      drive_push(2'b01, 8'h7E, 8'h00);
      exp_q.push_back({1'b0, 8'h7E});
      pop_check("mid_new_word");
      check_flags("mid_drained", 2'b00, 1'b1);
   endtask

   task automatic test_random_single();
      logic [7:0] v;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         v = 8'($urandom_range(0, 255));
         drive_push(2'b10, 8'h00, v);
         exp_q.push_back({1'b1, v});
      end
      for (int i = 0; i < 4; i++) pop_check("rand_s1");
      check_flags("rand_drained", 2'b00, 1'b1);
   endtask

   initial begin
      rst   = 1'b0;
      din   = '0;
      write = '0;
      read  = 1'b0;
      test_reset();
      test_fill();
      test_round_robin();
      test_full_push_pop();
      test_wrap();
      test_reset_mid();
      test_random_single();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
